// File: rtl/led_seq_ctrl_if.sv
// Host-side bundle for the LED pattern sequencer: memory write port, run control
// and the registered LED/status outputs.
interface led_seq_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             WR_EN;
  logic [AW-1:0]    WR_ADDR;
  logic [WIDTH-1:0] WR_DATA;
  logic             START;
  logic             STOP;
  logic [1:0]       MODE;
  logic [AW-1:0]    LAST;
  logic [WIDTH-1:0] LED;
  logic             BUSY;
  logic             DONE;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, START, STOP, MODE, LAST,
    input  LED, BUSY, DONE
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, START, STOP, MODE, LAST,
    output LED, BUSY, DONE
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: writable pattern memory stepped by a prescaler in loop,
// bounce or one-shot mode. LED_SEQ_DEFAULT_PATTERN_EN preloads a scanner pattern.
module led_seq_ctrl #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 19
) (
  input  logic           CLK,
  input  logic           RESET,
  led_seq_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

`ifdef LED_SEQ_DEFAULT_PATTERN_EN
  function automatic logic [DEPTH-1:0][WIDTH-1:0] f_scan_pat();
    logic [DEPTH-1:0][WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 8)       p[i] = WIDTH'(8'h01 << i);
      else if (i < 14) p[i] = WIDTH'(8'h01 << (14 - i));
    end
    return p;
  endfunction

  logic [DEPTH-1:0][WIDTH-1:0] r_mem = f_scan_pat();
`else
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
`endif

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_pc, w_pc_nxt;
  logic              r_dir, w_dir_nxt;     // 0 = up, 1 = down
  logic [DIV_BITS-1:0] r_presc, w_presc_nxt;
  logic [WIDTH-1:0]  r_led, w_led_nxt;
  logic              r_done, w_done_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [AW-1:0]     r_last, w_last_nxt;
  logic [AW:0]       w_last_ext;
  logic              w_tick;
  logic [AW-1:0]     w_next;

  // Reads use the pre-edge contents, so a same-cycle write returns old data.
  always_ff @(posedge CLK) begin
    if (bus.WR_EN) r_mem[bus.WR_ADDR] <= bus.WR_DATA;
  end

  assign w_last_ext = {1'b0, bus.LAST};
  assign w_tick     = (r_presc == '1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_dir   <= 1'b0;
      r_presc <= '0;
      r_led   <= '0;
      r_done  <= 1'b0;
      r_mode  <= 2'b00;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_dir   <= w_dir_nxt;
      r_presc <= w_presc_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
      r_mode  <= w_mode_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_dir_nxt   = r_dir;
    w_presc_nxt = r_presc;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_mode_nxt  = r_mode;
    w_last_nxt  = r_last;
    w_next      = r_pc;

    if (bus.STOP) begin
      w_state_nxt = IDLE;
      w_presc_nxt = '0;
    end else if (bus.START) begin
      w_state_nxt = RUN;
      w_pc_nxt    = '0;
      w_dir_nxt   = 1'b0;
      w_presc_nxt = '0;
      w_led_nxt   = r_mem[0];
      w_mode_nxt  = bus.MODE;
      w_last_nxt  = (w_last_ext > (AW+1)'(DEPTH-1)) ? AW'(DEPTH-1) : bus.LAST;
    end else if (r_state == RUN) begin
      w_presc_nxt = r_presc + 1'b1;
      if (w_tick) begin
        case (r_mode)
          2'b01: begin
            if (r_last == '0)        w_next = '0;
            else if (!r_dir) begin
              if (r_pc == r_last) begin
                w_dir_nxt = 1'b1;
                w_next    = r_pc - 1'b1;
              end else     w_next = r_pc + 1'b1;
            end else begin
              if (r_pc == '0) begin
                w_dir_nxt = 1'b0;
                w_next    = AW'(1);
              end else     w_next = r_pc - 1'b1;
            end
          end
          2'b10: begin
            if (r_pc == r_last) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_presc_nxt = '0;
            end else w_next = r_pc + 1'b1;
          end
          default: w_next = (r_pc == r_last) ? '0 : r_pc + 1'b1;
        endcase
        // One-shot completion leaves pc and LED on the final entry.
        w_pc_nxt  = w_next;
        w_led_nxt = r_mem[w_next];
      end
    end
  end

  assign bus.LED  = r_led;
  assign bus.BUSY = (r_state == RUN);
  assign bus.DONE = r_done;
endmodule
